control_multi: RTL and testbench

CONTROL_MULTI -- requirements
Module: control_multi

---
 rtl/control_multi_pkg.sv | 76 +++++++
 rtl/control_multi_out.sv | 80 ++++++++
 rtl/control_multi.sv | 100 ++++++++++
 tb/tb_control_multi.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_multi_pkg.sv
// Shared controller definitions: opcodes, state codes, mux selects, strobe bundle.
package control_multi_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned OP_W    = 6;
    localparam int unsigned FUNCT_W = 6;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned SEL_W   = 2;

    // Opcodes (instr[31:26])
    localparam logic [OP_W-1:0] R_FORMAT = 6'd0;
    localparam logic [OP_W-1:0] J        = 6'd2;
    localparam logic [OP_W-1:0] BEQ      = 6'd4;
    localparam logic [OP_W-1:0] BGTZ     = 6'd7;
    localparam logic [OP_W-1:0] ADDIU    = 6'd9;
    localparam logic [OP_W-1:0] LW       = 6'd35;
    localparam logic [OP_W-1:0] SW       = 6'd43;

    // Shift functs that take the shift amount from the immediate path
    localparam logic [FUNCT_W-1:0] FN_SLL = 6'd0;
    localparam logic [FUNCT_W-1:0] FN_SRL = 6'd2;

    // ALU-control class
    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-operand select
    localparam logic [SEL_W-1:0] SRCB_REG   = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR  = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM   = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_BROFF = 2'b11;

    // Next-PC select
    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    // Datapath strobes and selects produced by the output decoder
    typedef struct packed {
        logic             pc_write;
        logic             pc_write_cond;
        logic             i_or_d;
        logic             mem_read;
        logic             mem_write;
        logic             ir_write;
        logic             mem_to_reg;
        logic             reg_dst;
        logic             reg_write;
        logic             alu_src_a;
        logic             shamt;
        logic [SEL_W-1:0] pc_source;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
    } ctrl_t;

    function automatic logic is_shift(input logic [FUNCT_W-1:0] funct);
        return (funct == FN_SLL) || (funct == FN_SRL);
    endfunction

endpackage

// File: rtl/control_multi_out.sv
// Output decoder: strobes from current state, with mem_ready and shift-funct terms.
module control_multi_out
    import control_multi_pkg::*;
(
    input  state_e             state,
    input  logic [FUNCT_W-1:0] funct,
    input  logic               mem_ready,
    output ctrl_t              ctrl
);

    // Decode strobes; everything not named for a state stays 0
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.i_or_d    = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_BROFF;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALUOP_FUNCT;
                ctrl.alu_src_b = is_shift(funct) ? SRCB_IMM : SRCB_REG;
                ctrl.shamt     = is_shift(funct);
            end
            S_RWB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
                ctrl.shamt      = is_shift(funct);
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_REG;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
            end
            S_ADDIWB: begin
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.reg_write  = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_multi.sv
// Multi-cycle MIPS-style controller: state register, next-state logic, output decoder.
module control_multi
    import control_multi_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INSTR_W-1:0] instr,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic               Shamt,
    output logic               Illegal,
    output logic [SEL_W-1:0]   PCSource,
    output logic [SEL_W-1:0]   ALUSrcB,
    output logic [SEL_W-1:0]   ALUOp,
    output logic [STATE_W-1:0] state
);

    state_e            state_q;
    state_e            state_d;
    logic              illegal_c;
    logic              ready_gated_c;
    ctrl_t             ctrl;
    logic [OP_W-1:0]   opcode;

    assign opcode = instr[31:26];

    // State register; reset lands in FETCH immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection and single-cycle Illegal flag in DECODE
    always_comb begin
        state_d   = S_FETCH;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    R_FORMAT: state_d = (instr == '0) ? S_FETCH : S_EXEC;
                    LW, SW:   state_d = S_MEMADR;
                    BEQ, BGTZ: state_d = S_BRANCH;
                    J:        state_d = S_JUMP;
                    ADDIU:    state_d = S_ADDIEX;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (opcode == LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_RWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    // While reset is held the FETCH strobes must not see mem_ready
    assign ready_gated_c = mem_ready & rst_n;

    control_multi_out u_out (
        .state     (state_q),
        .funct     (instr[FUNCT_W-1:0]),
        .mem_ready (ready_gated_c),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign Shamt       = ctrl.shamt;
    assign PCSource    = ctrl.pc_source;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign Illegal     = illegal_c;
    assign state       = STATE_W'(state_q);

endmodule

// File: tb/tb_control_multi.sv
// Scoreboard bench for control_multi: per-instruction expected cycle traces vs. DUT.
module tb_control_multi;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        mem_ready;
    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic        MemtoReg, RegDst, RegWrite, ALUSrcA, Shamt, Illegal;
    logic [1:0]  PCSource, ALUSrcB, ALUOp;
    logic [3:0]  state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [21:0] exp_q[$];

    control_multi dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .Shamt(Shamt), .Illegal(Illegal),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {state, 12 strobes, PCSource, ALUSrcB, ALUOp}
    function automatic logic [21:0] act_vec();
        return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ALUSrcA, Shamt, Illegal,
                PCSource, ALUSrcB, ALUOp};
    endfunction

    // Reference: what each named step of an instruction must show on the controls
    function automatic logic [21:0] exp_vec(input int st, input bit rdy, input bit sh, input bit ill);
        bit pcw = 0, pcwc = 0, iord = 0, mrd = 0, mwr = 0, irw = 0;
        bit m2r = 0, rdst = 0, rw = 0, asa = 0, shm = 0, illo = 0;
        logic [1:0] pcs = 2'd0, asb = 2'd0, aop = 2'd0;
        case (st)
            0:  begin mrd = 1; asb = 2'd1; irw = rdy; pcw = rdy; end
            1:  begin asb = 2'd3; illo = ill; end
            2:  begin asa = 1; asb = 2'd2; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'd2; asb = sh ? 2'd2 : 2'd0; shm = sh; end
            7:  begin rdst = 1; rw = 1; shm = sh; end
            8:  begin asa = 1; aop = 2'd1; pcwc = 1; pcs = 2'd1; end
            9:  begin pcw = 1; pcs = 2'd2; end
            10: begin asa = 1; asb = 2'd2; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {4'(st), pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, shm, illo, pcs, asb, aop};
    endfunction

    task automatic chk(input string name, input logic [21:0] exp);
        logic [21:0] a;
        a = act_vec();
        n_tests++;
        if (a !== exp) begin
            n_fail++;
            $display("FAIL %s: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                     name, a[21:18], a[17:0], exp[21:18], exp[17:0]);
        end
    endtask

    // Monitor: every cycle the DUT presents outputs, compare against the next expectation
    initial begin
        logic [21:0] e, a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = act_vec();
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL cycle @%0t instr=%h rdy=%0b: got state=%0d ctl=%h, expected state=%0d ctl=%h",
                             $time, instr, mem_ready, a[21:18], a[17:0], e[21:18], e[17:0]);
                end
            end
        end
    end

    // Drive one cycle and queue what that cycle must look like
    task automatic cyc(input logic [31:0] ins, input bit rdy, input int st, input bit sh, input bit ill);
        @(posedge clk);
        #1;
        instr     = ins;
        mem_ready = rdy;
        exp_q.push_back(exp_vec(st, rdy, sh, ill));
    endtask

    // kind: 0 lw, 1 sw, 2 R-type, 3 nop, 4 beq, 5 bgtz, 6 j, 7 addiu, 8 illegal
    // fsel: forced funct (R-type) or forced opcode (illegal) when >= 0
    task automatic run_instr(input int kind, input int fw, input int mw, input int fsel);
        logic [31:0] ins;
        logic [5:0]  op;
        logic [5:0]  fn;
        bit          sh;
        bit          ill;
        ins = $urandom;
        sh  = 0;
        ill = 0;
        op  = 6'd0;
        case (kind)
            0: op = 6'd35;
            1: op = 6'd43;
            2: op = 6'd0;
            4: op = 6'd4;
            5: op = 6'd7;
            6: op = 6'd2;
            7: op = 6'd9;
            8: begin
                ill = 1;
                if (fsel >= 0) op = 6'(fsel);
                else begin
                    do op = 6'($urandom_range(0, 63));
                    while (op inside {6'd0, 6'd2, 6'd4, 6'd7, 6'd9, 6'd35, 6'd43});
                end
            end
            default: ;
        endcase
        ins[31:26] = op;
        if (kind == 2) begin
            if (fsel >= 0) fn = 6'(fsel);
            else begin
                case ($urandom_range(0, 3))
                    0: fn = 6'd0;
                    1: fn = 6'd2;
                    default: fn = 6'($urandom_range(0, 63));
                endcase
            end
            ins[5:0]   = fn;
            ins[15:11] = 5'($urandom_range(1, 31));
            sh = (fn == 6'd0) || (fn == 6'd2);
        end
        if (kind == 3) ins = 32'd0;

        // Instruction fetch; instr content is junk until the IR is loaded
        for (int i = 0; i < fw; i++) cyc($urandom, 1'b0, 0, 0, 0);
        cyc($urandom, 1'b1, 0, 0, 0);
        cyc(ins, 1'($urandom_range(0, 1)), 1, sh, ill);
        case (kind)
            0: begin
                cyc(ins, 1'($urandom_range(0, 1)), 2, sh, 0);
                for (int i = 0; i < mw; i++) cyc(ins, 1'b0, 3, sh, 0);
                cyc(ins, 1'b1, 3, sh, 0);
                cyc(ins, 1'($urandom_range(0, 1)), 4, sh, 0);
            end
            1: begin
                cyc(ins, 1'($urandom_range(0, 1)), 2, sh, 0);
                for (int i = 0; i < mw; i++) cyc(ins, 1'b0, 5, sh, 0);
                cyc(ins, 1'b1, 5, sh, 0);
            end
            2: begin
                cyc(ins, 1'($urandom_range(0, 1)), 6, sh, 0);
                cyc(ins, 1'($urandom_range(0, 1)), 7, sh, 0);
            end
            4, 5: cyc(ins, 1'($urandom_range(0, 1)), 8, sh, 0);
            6:    cyc(ins, 1'($urandom_range(0, 1)), 9, sh, 0);
            7: begin
                cyc(ins, 1'($urandom_range(0, 1)), 10, sh, 0);
                cyc(ins, 1'($urandom_range(0, 1)), 11, sh, 0);
            end
            default: ;
        endcase
    endtask

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b1;
        instr     = 32'h8c00_0000;
        #3;
        chk("reset_outputs", exp_vec(0, 0, 0, 0));
        @(posedge clk);
        #3;
        chk("reset_held_over_edge", exp_vec(0, 0, 0, 0));
        mem_ready = 1'b0;
        rst_n     = 1'b1;

        // Directed instruction traces
        run_instr(0, 0, 0, -1);   // lw, memory always ready
        run_instr(1, 0, 3, -1);   // sw, three wait cycles
        run_instr(2, 0, 0, 0);    // sll
        run_instr(2, 1, 0, 2);    // srl
        run_instr(2, 0, 0, 32);   // add
        run_instr(3, 0, 0, -1);   // nop
        run_instr(4, 0, 0, -1);   // beq
        run_instr(5, 0, 0, -1);   // bgtz
        run_instr(6, 0, 0, -1);   // j
        run_instr(7, 0, 0, -1);   // addiu
        run_instr(8, 0, 0, 63);   // illegal opcode 63
        run_instr(0, 2, 2, -1);   // lw with fetch and read waits

        // Randomized instruction stream
        for (int n = 0; n < 250; n++)
            run_instr($urandom_range(0, 8), $urandom_range(0, 2), $urandom_range(0, 3), -1);

        // Asynchronous reset in the middle of a stalled MEMRD
        cyc($urandom, 1'b1, 0, 0, 0);
        cyc(32'h8c00_1234, 1'b0, 1, 0, 0);
        cyc(32'h8c00_1234, 1'b0, 2, 0, 0);
        cyc(32'h8c00_1234, 1'b0, 3, 0, 0);
        @(posedge clk);
        #3;
        chk("memrd_stalled", exp_vec(3, 0, 0, 0));
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk("async_reset_mid_memrd", exp_vec(0, 0, 0, 0));
        @(posedge clk);
        #3;
        chk("reset_held_no_write", exp_vec(0, 0, 0, 0));
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        run_instr(0, 0, 1, -1);
        run_instr(2, 0, 0, 0);

        @(negedge clk);
        #1;
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
